pipeline_ctrl: RTL
==================

Name: pipeline_ctrl

Overview:
Central sequencer for the five-stage pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC. It generates every stage enable and flush, and the imem/dmem request strobes. It resolves instruction and data memory waits, load-use hazards, EX-stage redirects and halt draining. Sits beside the datapath; the pipeline registers consume its enable_*/flush_* outputs.

Parameters:
MAX_DMEM_WAIT, 1023, cycles a data request may wait for dhit before mem_timeout sets (counter width = $clog2(MAX_DMEM_WAIT+1)).

Ports:
CLK  input  1  clock
nRST  input  1  asynchronous active-low reset
ihit  input  1  instruction memory ready
dhit  input  1  data memory ready
dREN_EX_MEM, dWEN_EX_MEM  input  1 each  load/store held in the MEM stage
dREN_ID_EX  input  1  load held in the EX stage
Rt_ID_EX  input  5  load destination register in EX
Rs_IF_ID, Rt_IF_ID  input  5 each  source registers of the instruction in ID
redirect_EX  input  1  branch taken or jump resolved in EX
halt_EX_MEM, halt_MEM_WB  input  1 each  halt instruction in MEM / WB
pc_en  output  1  PC update enable
enable_IF_ID, enable_ID_EX, enable_EX_MEM, enable_MEM_WB  output  1 each  stage enables
flush_IF_ID, flush_ID_EX, flush_EX_MEM  output  1 each  synchronous bubble insert (applies only when the matching enable=1)
imemREN  output  1  instruction fetch request
dmemREN, dmemWEN  output  1 each  data request
dload_capture  output  1  datapath latches load data into its hold register
halt  output  1  CPU halted (registered, sticky)
mem_timeout  output  1  data wait exceeded MAX_DMEM_WAIT (registered, sticky)

Behaviour:
- Single clock CLK; nRST asynchronous active-low. Reset: state=RUN; ihit_seen=0, dmem_done=0, wait_cnt=0; halt=0, mem_timeout=0. While nRST=0, all enables, flushes, pc_en, imemREN, dmemREN, dmemWEN and dload_capture are forced to 0.
- States: RUN, DRAIN, HALTED.
- mem_op = dREN_EX_MEM | dWEN_EX_MEM.
- dmemREN = dREN_EX_MEM & ~dmem_done & state!=HALTED. dmemWEN is formed the same way from dWEN_EX_MEM.
- imemREN = (state==RUN) & ~ihit_seen.
- i_ok = ihit | ihit_seen | (state==DRAIN).
- d_ok = ~mem_op | dhit | dmem_done.
- advance = i_ok & d_ok & state!=HALTED.
- advance=0: every enable and pc_en is 0 and every flush is 0 (full freeze).
- advance=1: all four enables and pc_en are 1, then modified by the following, highest priority first:
  1. state==DRAIN: pc_en=0; flush_IF_ID=1; flush_ID_EX=1.
  2. redirect_EX: flush_IF_ID=1; flush_ID_EX=1; pc_en=1.
  3. load-use, defined as dREN_ID_EX & Rt_ID_EX!=0 & (Rt_ID_EX==Rs_IF_ID | Rt_ID_EX==Rt_IF_ID): pc_en=0; enable_IF_ID=0; flush_ID_EX=1.
- flush_EX_MEM is always 0 in this revision; the port is reserved for exceptions.
- Sticky flags, updated on clock:
  - advance=1 clears ihit_seen and dmem_done.
  - Otherwise ihit sets ihit_seen.
  - Otherwise mem_op & dhit sets dmem_done. Each access is issued exactly once even if the pipeline stays frozen.
- dload_capture = dREN_EX_MEM & dhit & ~advance, a one-cycle pulse.
- Transitions:
  - RUN→DRAIN on a clock with advance & halt_EX_MEM. Fetch stops; fetched instructions are flushed.
  - DRAIN→HALTED on the clock where halt_MEM_WB=1 and advance=1. halt is registered to 1 on that edge.
  - HALTED is left only by reset. In HALTED all outputs are 0 except halt and mem_timeout.
- Watchdog:
  - wait_cnt increments each cycle with (dmemREN|dmemWEN) & ~dhit.
  - It clears on dhit or when mem_op=0, and saturates at MAX_DMEM_WAIT.
  - On reaching MAX_DMEM_WAIT, mem_timeout sets sticky. mem_timeout does not alter sequencing.
- Simultaneous events:
  - dhit and ihit in the same cycle with no other wait: advance, with no flags set.
  - redirect_EX with load-use: redirect wins, so the load-use stall is discarded.
  - redirect_EX in DRAIN: ignored apart from the flushes.

Test Plan:
- Reset mid-run with dmem_done=1 and ihit_seen=1 → all outputs 0 immediately (asynchronous); after release: state RUN, imemREN=1, halt=0.
- Load at EX with Rt_ID_EX=5, Rs_IF_ID=5, ihit=1 → one cycle of pc_en=0, enable_IF_ID=0, flush_ID_EX=1. Repeat with Rt_ID_EX=0 → no stall.
- MEM load, dhit delayed 3 cycles with ihit=1 → 3 frozen cycles with dmemREN=1, then advance on the dhit cycle; wait_cnt returns to 0.
- dhit arrives while ihit=0 → dload_capture pulses once, dmemREN drops next cycle, and the pipeline advances when ihit=1 with no second request.
- redirect_EX=1 together with a load-use hazard and ihit=1 → flush_IF_ID=1, flush_ID_EX=1, pc_en=1.
- halt_EX_MEM=1 → imemREN=0 and pc_en=0 from the next cycle; after halt_MEM_WB=1 with advance, halt=1 is sticky. A data request held without dhit for 1023 cycles sets mem_timeout.

Source files
------------

// File: rtl/pipeline_ctrl.sv
// Pipeline sequencer: stage enables/flushes, PC enable and memory request strobes.
// Resolves imem/dmem waits, load-use stalls, EX redirects and halt draining.
//
// state  | meaning
// RUN    | normal fetch and execute
// DRAIN  | halt seen in MEM; fetch stopped, older instructions retire
// HALTED | halt reached WB; everything frozen until reset
module pipeline_ctrl #(
   parameter int MAX_DMEM_WAIT = 1023
) (
   input  logic       CLK,
   input  logic       nRST,
   input  logic       ihit,
   input  logic       dhit,
   input  logic       dREN_EX_MEM,
   input  logic       dWEN_EX_MEM,
   input  logic       dREN_ID_EX,
   input  logic [4:0] Rt_ID_EX,
   input  logic [4:0] Rs_IF_ID,
   input  logic [4:0] Rt_IF_ID,
   input  logic       redirect_EX,
   input  logic       halt_EX_MEM,
   input  logic       halt_MEM_WB,
   output logic       pc_en,
   output logic       enable_IF_ID,
   output logic       enable_ID_EX,
   output logic       enable_EX_MEM,
   output logic       enable_MEM_WB,
   output logic       flush_IF_ID,
   output logic       flush_ID_EX,
   output logic       flush_EX_MEM,
   output logic       imemREN,
   output logic       dmemREN,
   output logic       dmemWEN,
   output logic       dload_capture,
   output logic       halt,
   output logic       mem_timeout
);

   localparam int CW = $clog2(MAX_DMEM_WAIT + 1);
   localparam logic [CW-1:0] WAIT_MAX = CW'(MAX_DMEM_WAIT);
   localparam logic [CW-1:0] WAIT_TC  = CW'(MAX_DMEM_WAIT - 1);

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      DRAIN  = 2'd1,
      HALTED = 2'd2
   } state_t;

   state_t        state, state_nxt;
   logic          ihit_seen, dmem_done;
   logic [CW-1:0] wait_cnt;

   logic mem_op, active, dmem_rd, dmem_wr;
   logic i_ok, d_ok, advance, load_use;

   always_comb begin
      mem_op   = dREN_EX_MEM | dWEN_EX_MEM;
      active   = (state != HALTED);
      dmem_rd  = dREN_EX_MEM & ~dmem_done & active;
      dmem_wr  = dWEN_EX_MEM & ~dmem_done & active;
      i_ok     = ihit | ihit_seen | (state == DRAIN);
      d_ok     = ~mem_op | dhit | dmem_done;
      advance  = i_ok & d_ok & active;
      load_use = dREN_ID_EX & (Rt_ID_EX != 5'd0) &
                 ((Rt_ID_EX == Rs_IF_ID) | (Rt_ID_EX == Rt_IF_ID));
   end

   // Outputs: full freeze unless advancing; reset forces every strobe low.
   always_comb begin
      pc_en         = 1'b0;
      enable_IF_ID  = 1'b0;
      enable_ID_EX  = 1'b0;
      enable_EX_MEM = 1'b0;
      enable_MEM_WB = 1'b0;
      flush_IF_ID   = 1'b0;
      flush_ID_EX   = 1'b0;
      flush_EX_MEM  = 1'b0;
      imemREN       = 1'b0;
      dmemREN       = 1'b0;
      dmemWEN       = 1'b0;
      dload_capture = 1'b0;
      if (nRST) begin
         imemREN       = (state == RUN) & ~ihit_seen;
         dmemREN       = dmem_rd;
         dmemWEN       = dmem_wr;
         dload_capture = dREN_EX_MEM & dhit & ~advance & active;
         if (advance) begin
            pc_en         = 1'b1;
            enable_IF_ID  = 1'b1;
            enable_ID_EX  = 1'b1;
            enable_EX_MEM = 1'b1;
            enable_MEM_WB = 1'b1;
            if (state == DRAIN) begin
               pc_en       = 1'b0;
               flush_IF_ID = 1'b1;
               flush_ID_EX = 1'b1;
            end else if (redirect_EX) begin
               flush_IF_ID = 1'b1;
               flush_ID_EX = 1'b1;
            end else if (load_use) begin
               pc_en        = 1'b0;
               enable_IF_ID = 1'b0;
               flush_ID_EX  = 1'b1;
            end
         end
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         RUN:     if (advance && halt_EX_MEM) state_nxt = DRAIN;
         DRAIN:   if (advance && halt_MEM_WB) state_nxt = HALTED;
         HALTED:  state_nxt = HALTED;
         default: state_nxt = RUN;
      endcase
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state <= RUN;
         halt  <= 1'b0;
      end else begin
         state <= state_nxt;
         if (state == DRAIN && state_nxt == HALTED) halt <= 1'b1;
      end
   end

   // Sticky handshake flags keep each access from being re-issued while frozen.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         ihit_seen <= 1'b0;
         dmem_done <= 1'b0;
      end else if (advance) begin
         ihit_seen <= 1'b0;
         dmem_done <= 1'b0;
      end else if (ihit) begin
         ihit_seen <= 1'b1;
      end else if (mem_op && dhit) begin
         dmem_done <= 1'b1;
      end
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         wait_cnt    <= '0;
         mem_timeout <= 1'b0;
      end else begin
         if (!mem_op || dhit) begin
            wait_cnt <= '0;
         end else if ((dmem_rd || dmem_wr) && wait_cnt != WAIT_MAX) begin
            wait_cnt <= wait_cnt + CW'(1);
            if (wait_cnt == WAIT_TC) mem_timeout <= 1'b1;
         end
      end
   end

endmodule
